// File: rtl/gbn_arq_transmitter.sv
// -----------------------------------------------------------------------------
// gbn_arq_transmitter
//
// Go-Back-N ARQ transmitter. Packets from the network layer are copied into a
// sequence-indexed buffer and presented to the channel as frames. Up to WINDOW
// frames may be unacknowledged at once. A single retransmission timer covers
// the oldest outstanding frame. When it expires, every outstanding frame is
// re-sent starting from base. Frames are retired by cumulative, error-free ACKs.
//
// Optional feature macro: ARQ_RETRY_LIMIT_EN
//   defined   : consecutive timeouts are counted. The timeout that reaches
//               MAX_RETRY parks the block in FAIL with a sticky link_fail.
//               Only rstn leaves FAIL.
//   undefined : retries are unbounded and link_fail is tied low.
//
// Ports
//   clk             clock
//   rstn            synchronous, active-low reset
//   i_pkt_valid     packet offered by the network layer
//   i_pkt_data      packet payload
//   o_pkt_ready     packet accepted when i_pkt_valid && o_pkt_ready
//   o_tx_valid      frame presented to the channel
//   o_tx_seq        frame sequence number
//   o_tx_data       frame payload
//   i_tx_ready      channel takes the frame when o_tx_valid && i_tx_ready
//   i_ack_valid     ACK arrival strobe
//   i_ack_seq       cumulative ACK: next sequence expected by the receiver
//   i_ack_err       ACK corrupted (checksum failure)
//   o_outstanding   frames sent and not yet acknowledged
//   o_timeout_pulse one-cycle strobe on timer expiry
//   o_link_fail     sticky retry-limit failure
//   o_state         READY=0, RESEND=1, FAIL=2
// -----------------------------------------------------------------------------
module gbn_arq_transmitter #(
  parameter int unsigned SEQ_W     = 3,
  parameter int unsigned WINDOW    = 7,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned TIMEOUT   = 10,
  parameter int unsigned MAX_RETRY = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_pkt_valid,
  input  logic [DATA_W-1:0] i_pkt_data,
  output logic              o_pkt_ready,
  output logic              o_tx_valid,
  output logic [SEQ_W-1:0]  o_tx_seq,
  output logic [DATA_W-1:0] o_tx_data,
  input  logic              i_tx_ready,
  input  logic              i_ack_valid,
  input  logic [SEQ_W-1:0]  i_ack_seq,
  input  logic              i_ack_err,
  output logic [SEQ_W-1:0]  o_outstanding,
  output logic              o_timeout_pulse,
  output logic              o_link_fail,
  output logic [1:0]        o_state
);

  localparam int unsigned DEPTH   = 2 ** SEQ_W;
  localparam int unsigned TIMER_W = $clog2(TIMEOUT);

  localparam logic [SEQ_W-1:0]   WIN_LIM    = SEQ_W'(WINDOW);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  // Reject parameter sets the protocol logic cannot honour.
  if (TIMEOUT < 2 || WINDOW < 1 || WINDOW > DEPTH - 1 || MAX_RETRY < 1) begin : g_param_check
    $error("gbn_arq_transmitter: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_READY  = 2'd0,
    ST_RESEND = 2'd1,
    ST_FAIL   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [SEQ_W-1:0]    r_base;
  logic [SEQ_W-1:0]    r_next;
  logic [SEQ_W-1:0]    r_rs;
  logic [SEQ_W-1:0]    w_rs_next;
  logic [TIMER_W-1:0]  r_timer;
  logic                r_tx_valid;
  logic [SEQ_W-1:0]    r_tx_seq;
  logic [DATA_W-1:0]   r_tx_data;
  logic [DATA_W-1:0]   r_buf [DEPTH];

  logic [SEQ_W-1:0]    w_outst;
  logic [SEQ_W-1:0]    w_ack_d;
  logic                w_ack_ok;
  logic [SEQ_W-1:0]    w_base_new;
  logic                w_accept;
  logic [SEQ_W-1:0]    w_next_new;
  logic [SEQ_W-1:0]    w_outst_new;
  logic                w_timer_hit;
  logic                w_expire;
  logic                w_retry_fail;
  logic                w_tx_free;
  logic                w_resend_active;
  logic [SEQ_W-1:0]    w_rs_dist;
  logic [SEQ_W-1:0]    w_rs_cur;
  logic [SEQ_W-1:0]    w_last_seq;
  logic                w_rs_last;
  logic                w_load_rs;

  // Window occupancy and ACK position, both modulo the sequence space.
  assign w_outst  = r_next - r_base;
  assign w_ack_d  = i_ack_seq - r_base;

  // An ACK is only trusted when it is clean and retires at least one frame
  // that has actually been sent. Everything else is dropped silently.
  assign w_ack_ok = (r_state != ST_FAIL) && i_ack_valid && !i_ack_err &&
                    (w_ack_d != '0) && (w_ack_d <= w_outst);

  assign w_base_new = w_ack_ok ? i_ack_seq : r_base;

  // New packets are only taken while idle on the channel, so a fresh frame
  // never overwrites one still waiting for its handshake.
  assign o_pkt_ready = (r_state == ST_READY) && !r_tx_valid && (w_outst < WIN_LIM);
  assign w_accept    = i_pkt_valid && o_pkt_ready;

  assign w_next_new  = w_accept ? (r_next + 1'b1) : r_next;
  assign w_outst_new = w_next_new - w_base_new;

  // A clean ACK in the expiry cycle wins, so the timeout is suppressed.
  assign w_timer_hit = (r_state != ST_FAIL) && (w_outst != '0) && (r_timer == TIMER_LAST);
  assign w_expire    = w_timer_hit && !w_ack_ok;

  assign w_tx_free   = !r_tx_valid || i_tx_ready;

  // Resend pointer for this cycle. An expiry restarts from base. An ACK that
  // overtakes the pointer drags it forward to the new base.
  assign w_rs_dist = r_rs - r_base;
  assign w_rs_cur  = w_expire ? r_base :
                     (w_ack_ok && (w_rs_dist < w_ack_d)) ? i_ack_seq : r_rs;

  assign w_last_seq = r_next - 1'b1;
  assign w_rs_last  = (w_rs_cur == w_last_seq);

  // The expiry cycle itself already counts as resending, so the first
  // re-sent frame can be loaded without waiting a cycle in RESEND.
  assign w_resend_active = ((r_state == ST_RESEND) || w_expire) && !w_retry_fail;

  // A packet accepted in the expiry cycle takes the channel slot first. The
  // resend pass then starts on a later cycle and includes that frame too.
  assign w_load_rs = w_resend_active && (w_outst_new != '0) && w_tx_free && !w_accept;

`ifdef ARQ_RETRY_LIMIT_EN
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  logic [RETRY_W-1:0] r_retry;

  // Consecutive-timeout counter. Any clean ACK proves the link is alive.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_retry <= '0;
    end else if (w_ack_ok) begin
      r_retry <= '0;
    end else if (w_expire) begin
      r_retry <= r_retry + 1'b1;
    end
  end

  assign w_retry_fail = w_expire && (r_retry == RETRY_LAST);
  assign o_link_fail  = (r_state == ST_FAIL);
`else
  assign w_retry_fail = 1'b0;
  assign o_link_fail  = 1'b0;
`endif

  // State register plus resend pointer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_READY;
      r_rs    <= '0;
    end else begin
      r_state <= w_state_next;
      r_rs    <= w_rs_next;
    end
  end

  // Next-state logic. A resend pass ends once the newest outstanding frame
  // has been loaded, or as soon as an ACK empties the window.
  always_comb begin
    w_state_next = r_state;
    w_rs_next    = r_rs;
    unique case (r_state)
      ST_READY, ST_RESEND: begin
        if (w_retry_fail) begin
          w_state_next = ST_FAIL;
        end else if (w_resend_active) begin
          if (w_outst_new == '0) begin
            w_state_next = ST_READY;
          end else if (w_load_rs) begin
            w_rs_next    = w_rs_cur + 1'b1;
            w_state_next = w_rs_last ? ST_READY : ST_RESEND;
          end else begin
            w_rs_next    = w_rs_cur;
            w_state_next = ST_RESEND;
          end
        end
      end
      ST_FAIL: begin
        w_state_next = ST_FAIL;
      end
      default: begin
        w_state_next = ST_READY;
      end
    endcase
  end

  // Window pointers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_base <= '0;
      r_next <= '0;
    end else begin
      if (w_ack_ok) begin
        r_base <= i_ack_seq;
      end
      if (w_accept) begin
        r_next <= r_next + 1'b1;
      end
    end
  end

  // Retransmission timer. It sits at zero while nothing is outstanding, so a
  // first accept starts it from zero. Any retiring ACK or expiry restarts it.
  // In FAIL it is frozen because no further timeouts matter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_timer <= '0;
    end else if (r_state == ST_FAIL) begin
      r_timer <= r_timer;
    end else if (w_ack_ok || w_expire || (w_outst == '0)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Payload store. It is not reset: stale entries sit outside the window
  // after reset and are never read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_next] <= i_pkt_data;
    end
  end

  // Channel output register. A presented frame holds until it is handshaken
  // and only then may be replaced by a new or re-sent frame.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tx_valid <= 1'b0;
      r_tx_seq   <= '0;
      r_tx_data  <= '0;
    end else if (w_accept) begin
      r_tx_valid <= 1'b1;
      r_tx_seq   <= r_next;
      r_tx_data  <= i_pkt_data;
    end else if (w_load_rs) begin
      r_tx_valid <= 1'b1;
      r_tx_seq   <= w_rs_cur;
      r_tx_data  <= r_buf[w_rs_cur];
    end else if (i_tx_ready) begin
      r_tx_valid <= 1'b0;
    end
  end

  assign o_tx_valid      = r_tx_valid;
  assign o_tx_seq        = r_tx_seq;
  assign o_tx_data       = r_tx_data;
  assign o_outstanding   = w_outst;
  assign o_timeout_pulse = w_expire;
  assign o_state         = r_state;

endmodule

// File: tb/tb_gbn_arq_transmitter.sv
// -----------------------------------------------------------------------------
// tb_gbn_arq_transmitter
//
// Directed scenarios followed by a randomized phase for gbn_arq_transmitter.
// A reference model tracks the unacknowledged frames as a queue of payloads.
// It also tracks the resend position as an index into that queue. Expected
// outputs come from this model every cycle, and a few directed steps add
// fixed-value checks. Build with ARQ_RETRY_LIMIT_EN defined to cover FAIL.
// -----------------------------------------------------------------------------
module tb_gbn_arq_transmitter;

  localparam int SeqW     = 3;
  localparam int DataW    = 8;
  localparam int Window   = 7;
  localparam int Timeout  = 10;
  localparam int MaxRetry = 2;
  localparam int SeqMod   = 1 << SeqW;
`ifdef ARQ_RETRY_LIMIT_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             pktValid = 1'b0;
  logic [DataW-1:0] pktData = '0;
  logic             pktReady;
  logic             txValid;
  logic [SeqW-1:0]  txSeq;
  logic [DataW-1:0] txData;
  logic             txReady = 1'b0;
  logic             ackValid = 1'b0;
  logic [SeqW-1:0]  ackSeq = '0;
  logic             ackErr = 1'b0;
  logic [SeqW-1:0]  outstanding;
  logic             timeoutPulse;
  logic             linkFail;
  logic [1:0]       state;

  always #5 clk = ~clk;

  gbn_arq_transmitter #(
    .SEQ_W(SeqW), .WINDOW(Window), .DATA_W(DataW),
    .TIMEOUT(Timeout), .MAX_RETRY(MaxRetry)
  ) dut (
    .clk(clk), .rstn(rstn),
    .i_pkt_valid(pktValid), .i_pkt_data(pktData), .o_pkt_ready(pktReady),
    .o_tx_valid(txValid), .o_tx_seq(txSeq), .o_tx_data(txData), .i_tx_ready(txReady),
    .i_ack_valid(ackValid), .i_ack_seq(ackSeq), .i_ack_err(ackErr),
    .o_outstanding(outstanding), .o_timeout_pulse(timeoutPulse),
    .o_link_fail(linkFail), .o_state(state)
  );

  int nCompared = 0;
  int nMismatched = 0;

  // Reference model: unacked payloads oldest-first, the sequence number of
  // the oldest one, and the index of the next frame to re-send.
  logic [DataW-1:0] mQueue[$];
  int               mBase = 0;
  int               mTimer = 0;
  int               mRsIdx = 0;
  int               mRetry = 0;
  bit               mResending = 1'b0;
  bit               mFailed = 1'b0;
  bit               mTxValid = 1'b0;
  int               mTxSeq = 0;
  logic [DataW-1:0] mTxData = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mQueue.delete();
    mBase = 0;
    mTimer = 0;
    mRsIdx = 0;
    mRetry = 0;
    mResending = 1'b0;
    mFailed = 1'b0;
    mTxValid = 1'b0;
    mTxSeq = 0;
    mTxData = '0;
  endtask

  // One clock cycle: drive inputs, compare DUT against the model mid-cycle,
  // advance the model, then step past the rising edge.
  task automatic applyStimulus(input bit pv, input logic [DataW-1:0] pd, input bit tr,
                               input bit av, input int as, input bit ae, input bit rn);
    int outst;
    int nxt;
    int d;
    int expState;
    bit expReady;
    bit ackOk;
    bit expire;
    bit accept;
    bit txFree;
    bit failNow;
    rstn = rn;
    pktValid = pv;
    pktData = pd;
    txReady = tr;
    ackValid = av;
    ackSeq = SeqW'(as);
    ackErr = ae;
    @(negedge clk);
    if (!rn) begin
      modelReset();
    end else begin
      outst = mQueue.size();
      nxt = (mBase + outst) % SeqMod;
      d = (int'(ackSeq) - mBase + SeqMod) % SeqMod;
      expReady = !mFailed && !mResending && !mTxValid && (outst < Window);
      ackOk = !mFailed && av && !ae && (d >= 1) && (d <= outst);
      expire = !mFailed && (outst > 0) && (mTimer == Timeout - 1) && !ackOk;
      accept = pv && expReady;
      expState = mFailed ? 2 : (mResending ? 1 : 0);

      checkOutput("pkt_ready", 32'(pktReady), 32'(expReady));
      checkOutput("tx_valid", 32'(txValid), 32'(mTxValid));
      checkOutput("tx_seq", 32'(txSeq), 32'(mTxSeq));
      checkOutput("tx_data", 32'(txData), 32'(mTxData));
      checkOutput("outstanding", 32'(outstanding), 32'(outst));
      checkOutput("timeout_pulse", 32'(timeoutPulse), 32'(expire));
      checkOutput("link_fail", 32'(linkFail), 32'(mFailed));
      checkOutput("state", 32'(state), 32'(expState));

      txFree = !mTxValid || tr;
      if (ackOk) begin
        repeat (d) void'(mQueue.pop_front());
        mBase = (mBase + d) % SeqMod;
        mRetry = 0;
        mRsIdx = (mRsIdx > d) ? mRsIdx - d : 0;
      end
      if (accept) mQueue.push_back(pd);
      if (ackOk || expire || outst == 0) mTimer = 0;
      else mTimer = mTimer + 1;
      failNow = expire && RetryEn && (mRetry + 1 >= MaxRetry);
      if (expire) mRetry = mRetry + 1;
      if (failNow) begin
        mFailed = 1'b1;
        mResending = 1'b0;
      end else if (expire) begin
        mResending = 1'b1;
        mRsIdx = 0;
      end
      if (mQueue.size() == 0) mResending = 1'b0;
      if (accept) begin
        mTxValid = 1'b1;
        mTxSeq = nxt;
        mTxData = pd;
      end else if (mResending && txFree) begin
        mTxValid = 1'b1;
        mTxSeq = (mBase + mRsIdx) % SeqMod;
        mTxData = mQueue[mRsIdx];
        mRsIdx = mRsIdx + 1;
        if (mRsIdx == mQueue.size()) mResending = 1'b0;
      end else if (tr) begin
        mTxValid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [DataW-1:0] pd;
    int ackPick;
    bit pv;
    bit tr;
    bit av;
    bit ae;
    bit rn;

    $display("[TB] starting gbn_arq_transmitter bench");

    // Reset values.
    resetDut();
    resetDut();
    checkOutput("rst_tx_valid", 32'(txValid), 32'd0);
    checkOutput("rst_tx_seq", 32'(txSeq), 32'd0);
    checkOutput("rst_tx_data", 32'(txData), 32'd0);
    checkOutput("rst_outstanding", 32'(outstanding), 32'd0);
    checkOutput("rst_link_fail", 32'(linkFail), 32'd0);
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_pkt_ready", 32'(pktReady), 32'd1);

    // Window fill: packets offered continuously, no ACKs.
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0, 0, 1'b0, 1'b1);
    checkOutput("fill_outstanding", 32'(outstanding), 32'd7);
    checkOutput("fill_pkt_ready", 32'(pktReady), 32'd0);

    // Cumulative ACK: four frames, then ACK 3 and ACK 4.
    resetDut();
    for (int i = 0; i < 8; i++) applyStimulus(i % 2 == 0, 8'(8'h10 + i), 1'b1, 1'b0, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 3, 1'b0, 1'b1);
    checkOutput("cum_ack_outst1", 32'(outstanding), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 4, 1'b0, 1'b1);
    checkOutput("cum_ack_outst0", 32'(outstanding), 32'd0);
    idleCycles(15);

    // Discards, then a plain go-back resend of seq 0,1,2.
    resetDut();
    for (int i = 0; i < 6; i++) applyStimulus(i % 2 == 0, 8'(8'h20 + i), 1'b1, 1'b0, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 2, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 5, 1'b0, 1'b1);
    checkOutput("discard_outst", 32'(outstanding), 32'd3);
    idleCycles(20);

    // Mid-resend ACK 2 while frame 0 is being re-sent.
    resetDut();
    for (int i = 0; i < 6; i++) applyStimulus(i % 2 == 0, 8'(8'h30 + i), 1'b1, 1'b0, 0, 1'b0, 1'b1);
    idleCycles(5);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 2, 1'b0, 1'b1);
    checkOutput("midack_hold_valid", 32'(txValid), 32'd1);
    checkOutput("midack_hold_seq", 32'(txSeq), 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    checkOutput("midack_next_seq", 32'(txSeq), 32'd2);
    checkOutput("midack_next_data", 32'(txData), 32'h34);
    checkOutput("midack_outst", 32'(outstanding), 32'd1);
    idleCycles(4);

    // ACK arriving in the expiry cycle.
    resetDut();
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    idleCycles(9);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1, 1'b0, 1'b1);
    checkOutput("expack_outst", 32'(outstanding), 32'd0);
    checkOutput("expack_state", 32'(state), 32'd0);
    idleCycles(12);

    // Channel stalled for five cycles.
    resetDut();
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      checkOutput("stall_valid", 32'(txValid), 32'd1);
      checkOutput("stall_seq", 32'(txSeq), 32'd0);
      checkOutput("stall_data", 32'(txData), 32'hA5);
    end
    idleCycles(3);

    // Streaming with ACKs so the sequence wraps.
    resetDut();
    for (int i = 0; i < 44; i++) begin
      av = (mQueue.size() > 0);
      applyStimulus(1'b1, 8'($urandom), 1'b1, av, (mBase + mQueue.size()) % SeqMod, 1'b0, 1'b1);
    end

`ifdef ARQ_RETRY_LIMIT_EN
    // Retry limit: one resend, then FAIL, then a one-cycle reset.
    resetDut();
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    idleCycles(25);
    checkOutput("fail_state", 32'(state), 32'd2);
    checkOutput("fail_link", 32'(linkFail), 32'd1);
    checkOutput("fail_pkt_ready", 32'(pktReady), 32'd0);
    resetDut();
    checkOutput("fail_rst_state", 32'(state), 32'd0);
    checkOutput("fail_rst_link", 32'(linkFail), 32'd0);
    checkOutput("fail_rst_outst", 32'(outstanding), 32'd0);
    checkOutput("fail_rst_tx_valid", 32'(txValid), 32'd0);
    checkOutput("fail_rst_pkt_ready", 32'(pktReady), 32'd1);
`else
    checkOutput("link_fail_tied", 32'(linkFail), 32'd0);
`endif

    // Randomized phase.
    resetDut();
    for (int i = 0; i < 900; i++) begin
      pv = ($urandom_range(0, 1) == 1);
      pd = 8'($urandom);
      tr = ($urandom_range(0, 3) != 0);
      av = ($urandom_range(0, 2) == 0);
      ae = ($urandom_range(0, 7) == 0);
      rn = ($urandom_range(0, 249) != 0);
      if (mQueue.size() > 0 && $urandom_range(0, 3) != 0)
        ackPick = (mBase + int'($urandom_range(1, mQueue.size()))) % SeqMod;
      else
        ackPick = int'($urandom_range(0, SeqMod - 1));
      applyStimulus(pv, pd, tr, av, ackPick, ae, rn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
